// File: rtl/raiz_scheduler_if.sv
// Request/response and datapath bundles for the raiz square-root scheduler.
// master drives the request side / datapath controls respectively.
interface raiz_req_if #(
  parameter int N    = 8,
  parameter int NREQ = 4,
  parameter int CW   = 4
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   req;
  logic [NREQ*N-1:0] req_data;
  logic [NREQ-1:0]   ack;
  logic              busy;
  logic              resp_valid;
  logic [IW-1:0]     resp_id;
  logic [N/2-1:0]    resp_data;
  logic [CW-1:0]     resp_cycles;
  logic              resp_err;

  modport master (
    output req, req_data,
    input  ack, busy, resp_valid,
    input  resp_id, resp_data,
    input  resp_cycles, resp_err
  );

  modport slave (
    input  req, req_data,
    output ack, busy, resp_valid,
    output resp_id, resp_data,
    output resp_cycles, resp_err
  );
endinterface

interface raiz_dp_if #(
  parameter int N  = 8,
  parameter int CW = 4
);
  logic           dp_start;
  logic           dp_abort;
  logic [N-1:0]   dp_data_in;
  logic           dp_done;
  logic [N/2-1:0] dp_data_out;
  logic [CW-1:0]  dp_cycles;

  modport master (
    output dp_start, dp_abort, dp_data_in,
    input  dp_done, dp_data_out, dp_cycles
  );

  modport slave (
    input  dp_start, dp_abort, dp_data_in,
    output dp_done, dp_data_out, dp_cycles
  );
endinterface

// File: rtl/raiz_scheduler.sv
// Round-robin arbiter sharing one iterative sqrt datapath,
// with a watchdog that aborts a hung computation.
module raiz_scheduler #(
  parameter int N       = 8,
  parameter int NREQ    = 4,
  parameter int CW      = 4,
  parameter int TIMEOUT = 32
) (
  input  logic      clock,
  input  logic      reset,
  raiz_req_if.slave rq,
  raiz_dp_if.master dp
);
  localparam int IW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]    state;
  logic [IW-1:0] last_grant;
  logic [TW-1:0] timer;
  logic [IW-1:0] pick;

  function automatic logic [IW-1:0] wrap(input int v);
    return IW'(v % NREQ);
  endfunction

  // Scan farthest-first so the nearest set bit after last_grant wins.
  always_comb begin
    pick = last_grant;
    for (int i = NREQ; i >= 1; i--) begin
      if (rq.req[wrap(int'(last_grant) + i)])
        pick = wrap(int'(last_grant) + i);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      last_grant     <= IW'(NREQ - 1);
      timer          <= '0;
      rq.ack         <= '0;
      rq.busy        <= 1'b0;
      rq.resp_valid  <= 1'b0;
      rq.resp_id     <= '0;
      rq.resp_data   <= '0;
      rq.resp_cycles <= '0;
      rq.resp_err    <= 1'b0;
      dp.dp_start    <= 1'b0;
      dp.dp_abort    <= 1'b0;
      dp.dp_data_in  <= '0;
    end else begin
      rq.ack        <= '0;
      rq.resp_valid <= 1'b0;
      dp.dp_start   <= 1'b0;
      dp.dp_abort   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (|rq.req) begin
            dp.dp_data_in <= rq.req_data[int'(pick)*N +: N];
            rq.resp_id    <= pick;
            rq.ack        <= NREQ'(1) << pick;
            dp.dp_start   <= 1'b1;
            rq.busy       <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          timer      <= '0;
          last_grant <= rq.resp_id;
          state      <= WAIT;
        end
        WAIT: begin
          if (dp.dp_done) begin
            rq.resp_data   <= dp.dp_data_out;
            rq.resp_cycles <= dp.dp_cycles;
            rq.resp_err    <= 1'b0;
            rq.resp_valid  <= 1'b1;
            state          <= RESP;
          end else if (timer == TLAST) begin
            dp.dp_abort    <= 1'b1;
            rq.resp_data   <= '0;
            rq.resp_cycles <= '0;
            rq.resp_err    <= 1'b1;
            rq.resp_valid  <= 1'b1;
            state          <= RESP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RESP: begin
          rq.busy <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_raiz_scheduler.sv
// Scoreboard bench for raiz_scheduler: random requesters, a
// behavioural datapath model and a reference round-robin arbiter.
module tb_raiz_scheduler;
  localparam int N       = 8;
  localparam int NREQ    = 4;
  localparam int CW      = 4;
  localparam int TIMEOUT = 32;
  localparam int RW      = N / 2;

  typedef struct {
    int id;
    int data;
    int cyc;
    int err;
    int delta;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  raiz_req_if #(.N(N), .NREQ(NREQ), .CW(CW)) rq ();
  raiz_dp_if  #(.N(N), .CW(CW)) dp ();

  raiz_scheduler #(
    .N(N), .NREQ(NREQ), .CW(CW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .rq   (rq.slave),
    .dp   (dp.master)
  );

  logic [NREQ-1:0] req_r;
  logic [N-1:0]    ops [NREQ];

  assign rq.req = req_r;
  always_comb begin
    rq.req_data = '0;
    for (int i = 0; i < NREQ; i++) rq.req_data[i*N +: N] = ops[i];
  end

  int   errors = 0;
  int   checks = 0;
  int   model_last = NREQ - 1;
  int   plan[$];
  int   glog[$];
  exp_t exp_q[$];
  int   dp_lat = 1;
  bit   hold_all = 1'b0;
  bit   spur = 1'b0;
  int   cyc = 0;
  int   start_cyc = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  function automatic int isqrt(input int x);
    int r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  function automatic int rr(input int last, input logic [NREQ-1:0] r);
    for (int i = 1; i <= NREQ; i++) begin
      int k = (last + i) % NREQ;
      if (r[k]) return k;
    end
    return -1;
  endfunction

  function automatic int rand_lat();
    int r = $urandom_range(0, 9);
    if (r == 0) return 0;
    if (r == 1) return TIMEOUT;
    return $urandom_range(1, 12);
  endfunction

  // A grant was made on the last edge: predict it and queue the response.
  task automatic grant();
    int   g;
    int   gd;
    int   lat;
    bit   keep;
    exp_t e;
    g  = rr(model_last, req_r);
    gd = -1;
    for (int i = 0; i < NREQ; i++) if (rq.ack[i]) gd = i;
    chk("ack_onehot", int'(rq.ack), (g < 0) ? 0 : (1 << g));
    glog.push_back(gd);
    if (g < 0) return;
    lat     = (plan.size() != 0) ? plan.pop_front() : rand_lat();
    dp_lat  = lat;
    e.id    = g;
    e.err   = (lat == 0) ? 1 : 0;
    e.data  = e.err ? 0 : isqrt(int'(ops[g]));
    e.cyc   = e.err ? 0 : (lat % (1 << CW));
    e.delta = e.err ? TIMEOUT + 1 : lat + 1;
    exp_q.push_back(e);
    model_last = g;
    keep = hold_all || (spur && $urandom_range(0, 3) == 0);
    if (!keep) req_r[g] = 1'b0;
    else if (spur) ops[g] = N'($urandom);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    if (rq.ack != '0) grant();
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (req_r == '0 && exp_q.size() == 0 && !rq.busy) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) chk("idle_timeout", 0, 1);
  endtask

  task automatic wait_grants(input int target);
    for (int i = 0; i < 400 && glog.size() < target; i++) step();
    if (glog.size() < target) chk("grant_timeout", glog.size(), target);
  endtask

  // Datapath model: done L cycles after the start, or never when L is 0.
  initial begin
    bit          active = 1'b0;
    int          k = 0;
    int          lat = 0;
    logic [N-1:0] op = '0;
    dp.dp_done     = 1'b0;
    dp.dp_data_out = '0;
    dp.dp_cycles   = '0;
    forever begin
      @(negedge clock);
      dp.dp_done = 1'b0;
      if (reset || dp.dp_abort) begin
        active = 1'b0;
      end else if (dp.dp_start) begin
        active = 1'b1;
        k      = 0;
        lat    = dp_lat;
        op     = dp.dp_data_in;
      end else if (active) begin
        k++;
        if (lat != 0 && k == lat) begin
          dp.dp_done     = 1'b1;
          dp.dp_data_out = RW'(isqrt(int'(op)));
          dp.dp_cycles   = CW'(lat);
          active         = 1'b0;
        end
      end else if (spur && $urandom_range(0, 7) == 0) begin
        dp.dp_done     = 1'b1;
        dp.dp_data_out = RW'($urandom);
        dp.dp_cycles   = CW'($urandom);
      end
    end
  end

  // Response monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      cyc++;
      if (!reset) begin
        if (dp.dp_start) begin
          start_cyc = cyc;
          chk("start_with_ack", int'(rq.ack != '0), 1);
        end
        if (dp.dp_abort && !rq.resp_valid) chk("abort_without_resp", 1, 0);
        if (rq.resp_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_resp", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("resp_id", int'(rq.resp_id), e.id);
            chk("resp_data", int'(rq.resp_data), e.data);
            chk("resp_cycles", int'(rq.resp_cycles), e.cyc);
            chk("resp_err", int'(rq.resp_err), e.err);
            chk("dp_abort", int'(dp.dp_abort), e.err);
            chk("resp_latency", cyc - start_cyc, e.delta);
          end
        end
      end
    end
  end

  initial begin
    int n0;
    int exp2[5] = '{0, 1, 2, 3, 0};
    logic [NREQ-1:0] rpat[2] = '{4'b0010, 4'b1001};
    int rexp[2] = '{1, 0};
    req_r = '0;
    for (int i = 0; i < NREQ; i++) ops[i] = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_outputs",
        int'(|{rq.busy, rq.ack, rq.resp_valid, rq.resp_id, rq.resp_data,
               rq.resp_cycles, rq.resp_err, dp.dp_start, dp.dp_abort,
               dp.dp_data_in}), 0);
    reset = 1'b0;

    // All four held high: plain rotation with wrap.
    ops      = '{8'd0, 8'd1, 8'd255, 8'd100};
    hold_all = 1'b1;
    plan     = '{3, 4, 2, 6, 1};
    req_r    = '1;
    n0       = glog.size();
    wait_grants(n0 + 5);
    req_r    = '0;
    hold_all = 1'b0;
    wait_idle();
    if (glog.size() >= n0 + 5)
      for (int i = 0; i < 5; i++)
        chk($sformatf("rotate_grant%0d", i), glog[n0+i], exp2[i]);

    // Single request, 5-cycle datapath.
    ops[0] = 8'd144;
    plan   = '{5};
    req_r  = 4'b0001;
    wait_idle();

    // Wrap from id 2 back to id 0, then id 2.
    ops[2] = 8'd50;
    plan   = '{2};
    req_r  = 4'b0100;
    wait_idle();
    n0     = glog.size();
    ops[0] = 8'd81;
    ops[2] = 8'd200;
    plan   = '{3, 3};
    req_r  = 4'b0101;
    wait_idle();
    if (glog.size() >= n0 + 2) begin
      chk("wrap_grant0", glog[n0], 0);
      chk("wrap_grant1", glog[n0+1], 2);
    end

    // Hung datapath, then a normal transaction.
    ops[1] = 8'd99;
    plan   = '{0, 7};
    req_r  = 4'b0010;
    wait_idle();
    ops[1] = 8'd225;
    req_r  = 4'b0010;
    wait_idle();

    // Done exactly in the timeout cycle.
    ops[3] = 8'd169;
    plan   = '{TIMEOUT};
    req_r  = 4'b1000;
    wait_idle();

    // Random traffic with drops, re-requests and stray dp_done.
    spur = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      step();
      for (int i = 0; i < NREQ; i++) begin
        if (req_r[i]) begin
          if (rq.ack == '0 && $urandom_range(0, 31) == 0) req_r[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          ops[i]   = N'($urandom);
          req_r[i] = 1'b1;
        end
      end
    end
    spur  = 1'b0;
    req_r = '0;
    wait_idle();

    // Async reset mid-WAIT; arbitration restarts from id 0.
    for (int t = 0; t < 2; t++) begin
      ops[2] = 8'd77;
      plan   = '{0};
      req_r  = 4'b0100;
      repeat (8) step();
      chk("busy_before_reset", int'(rq.busy), 1);
      #1;
      reset = 1'b1;
      #1;
      chk("async_reset",
          int'(|{rq.busy, rq.ack, dp.dp_start, rq.resp_valid, dp.dp_abort}), 0);
      exp_q.delete();
      plan.delete();
      req_r      = '0;
      model_last = NREQ - 1;
      step();
      step();
      reset  = 1'b0;
      n0     = glog.size();
      ops[0] = 8'd64;
      ops[1] = 8'd10;
      ops[3] = 8'd3;
      req_r  = rpat[t];
      wait_idle();
      if (glog.size() > n0) chk($sformatf("post_reset_grant%0d", t), glog[n0], rexp[t]);
      else chk($sformatf("post_reset_grant%0d", t), -1, rexp[t]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
